video_pixel_serializer: RTL and testbench
=========================================

# video_pixel_serializer

Pixel-generation stage upstream of the analogue colour encoder. Accepts bitmap/attribute byte pairs from the video fetch unit and shifts them out at the 7 MHz pixel rate. Applies border, blanking and FLASH, and resolves each pixel to a 3-3-2 RGB code (r/g 3 bits, b 2 bits). Also generates the frame/pixel-alternating `strobe` the encoder uses for temporal dithering.

## Interface
Parameters:
- none

Ports:
- `clk28` in 1 — 28 MHz system clock
- `rst` in 1 — synchronous, active-high reset
- `load` in 1 — new byte pair valid; sampled only in pixel-enable cycles
- `bitmap` in 8 — pixel byte, MSB shown first
- `attr` in 8 — attribute: [7] flash, [6] bright, [5:3] paper GRB, [2:0] ink GRB
- `border` in 3 — border colour GRB
- `screen_active` in 1 — 1 = paper area, 0 = border area; sampled in pixel-enable cycles
- `blank` in 1 — 1 = force black; sampled in pixel-enable cycles
- `frame_start` in 1 — single-cycle pulse once per frame
- `pal_wr` in 1 — palette write strobe (ULAplus build only, otherwise ignored)
- `pal_addr` in 6 — palette entry index
- `pal_data` in 8 — palette entry data, GGGRRRBB
- `ulaplus_mode` in 1 — 1 = palette colour path (ULAplus build only)
- `r` out 3, `g` out 3, `b` out 2 — registered pixel colour
- `strobe` out 1 — registered dither phase

## Operation

**Pixel enable**
- 2-bit counter `phase` increments every `clk28`; reset 0.
- `pix_ce` = (`phase` == 3), i.e. 1 of every 4 clocks.

**Shifter (`pix_ce` cycles only)**
- `load`=1:
  - shifter <= `bitmap`
  - attr latch <= `attr`
  - area flag <= `screen_active`
  - blank flag <= `blank`
- `load`=0:
  - shifter <= shifter << 1, zero fill; an exhausted shifter shows paper
  - attr latch holds
  - area and blank flags resample their inputs
- `load` outside `pix_ce` is ignored.

**FLASH**
- 5-bit frame counter, +1 on `frame_start`, wraps 31→0; reset 0.
- `flash_ph` = counter[4].
- When attr[7] & `flash_ph`, ink and paper are swapped.

**Colour resolve (standard path)**
- Index selection:
  - blank flag=1 → 0,0,0.
  - area flag=0 → border colour, bright=0.
  - otherwise → ink if shifter[7], else paper.
- Level map:
  - r/g: off → 3'b000; on, bright=0 → 3'b101; on, bright=1 → 3'b111.
  - b: off → 2'b00; on → 2'b10 (bright=0) or 2'b11 (bright=1).

**Strobe**
- `pix_par` toggles on every `pix_ce`; reset 0.
- `frame_par` toggles on `frame_start`; reset 0.
- `strobe` <= `pix_par` ^ `frame_par`, updated together with the colour outputs.

## Timing
- Reset values: `r`=0, `g`=0, `b`=0, `strobe`=0, shifter=0, attr latch=0, area flag=0, blank flag=1.
- Colour outputs and `strobe` update in the cycle after `pix_ce` (`phase`==0), then hold for 4 clocks.
- Latency: `load` sampled at edge N (the `pix_ce` cycle) → first pixel visible after edge N+1; pixel k visible after edge N+1+4k.
- `frame_start` coinciding with `pix_ce`: counter, `frame_par` and shifter all update in that cycle; no priority conflict.
- Reset mid-line: all state returns to reset values on the next edge; output is black until the next `load`.

## Configuration
- Macro: `ULAPLUS_EN`.

With `ULAPLUS_EN` defined:
- Adds a 64×8 palette register file. Contents are not reset.
- `pal_wr`=1 writes `pal_data` to `pal_addr` on that edge, in any cycle.
- When `ulaplus_mode`=1, palette indices are:
  - ink = {attr[7:6], 1'b0, attr[2:0]}
  - paper = {attr[7:6], 1'b1, attr[5:3]}
  - border = {2'b00, 1'b1, border}
- Output in palette mode: `g`=entry[7:5], `r`=entry[4:2], `b`=entry[1:0].
- FLASH and bright are disabled in palette mode; blank still forces black.
- Write-during-read: a write to the entry being read in the same cycle shows the old data; the new data appears from the next output update.

Without `ULAPLUS_EN`:
- No palette storage.
- `pal_*` and `ulaplus_mode` are unused; only the standard path exists.

## Test plan
- Reset, then release → r/g/b=0 and `strobe`=0 until the first `load`; `phase` starts at 0.
- `load` with bitmap=8'hA5, attr=8'h47, screen_active=1, blank=0 → output sequence, 4 clocks each:
  - ink = white bright (7,7,3) on 1-bits, paper = black (0,0,0) on 0-bits
  - pattern 1,0,1,0,0,1,0,1
  - first pixel after `pix_ce`+1.
- screen_active=0, border=3'b010 → r=3'b101, g=0, b=0; blank=1 → all 0.
- attr=8'h87, bitmap=8'hFF, 16 `frame_start` pulses → output toggles from white (5,5,2) to black; flips again after 16 more.
- Strobe → toggles every 4 clocks; phase inverted after one `frame_start`.
- `ULAPLUS_EN` build: write entry 1 = 8'hE3, set ulaplus_mode=1, attr=8'h01, bitmap=8'h80 → first pixel g=7, r=0, b=3; following pixels use entry 8.

Source files
------------

// File: rtl/video_pixel_serializer.sv
// video_pixel_serializer
// Shifts bitmap/attribute byte pairs out at the 7 MHz pixel rate (one pixel
// every four clk28 cycles), applies border, blanking and FLASH, and resolves
// each pixel to a registered 3-3-2 RGB code plus a temporal dither strobe.
// Optional build macro: ULAPLUS_EN adds a 64x8 palette colour path.
module video_pixel_serializer (
  input  logic       clk28,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] bitmap,
  input  logic [7:0] attr,
  input  logic [2:0] border,
  input  logic       screen_active,
  input  logic       blank,
  input  logic       frame_start,
  input  logic       pal_wr,
  input  logic [5:0] pal_addr,
  input  logic [7:0] pal_data,
  input  logic       ulaplus_mode,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [1:0] b,
  output logic       strobe
);

  // Intensity for one red/green channel of a GRB index.
  function automatic logic [2:0] level3(input logic lit, input logic bright);
    logic [2:0] lvl;
    if (!lit) begin
      lvl = 3'b000;
    end else if (bright) begin
      lvl = 3'b111;
    end else begin
      lvl = 3'b101;
    end
    return lvl;
  endfunction

  // Intensity for the blue channel of a GRB index.
  function automatic logic [1:0] level2(input logic lit, input logic bright);
    logic [1:0] lvl;
    if (!lit) begin
      lvl = 2'b00;
    end else if (bright) begin
      lvl = 2'b11;
    end else begin
      lvl = 2'b10;
    end
    return lvl;
  endfunction

  logic [1:0] phase_q, phase_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] attr_q, attr_d;
  logic       area_q, area_d;
  logic       blank_q, blank_d;
  logic [4:0] flash_cnt_q, flash_cnt_d;
  logic       pix_par_q, pix_par_d;
  logic       frame_par_q, frame_par_d;
  logic [2:0] r_q, r_d;
  logic [2:0] g_q, g_d;
  logic [1:0] b_q, b_d;
  logic       strobe_q, strobe_d;

  logic       pix_ce_s;
  logic       out_en_s;
  logic [2:0] ink_s;
  logic [2:0] paper_s;
  logic [2:0] idx_s;
  logic       bright_s;
  logic [2:0] col_r_s;
  logic [2:0] col_g_s;
  logic [1:0] col_b_s;

  assign pix_ce_s = (phase_q == 2'd3);
  // Outputs are refreshed in the cycle after pix_ce, so they track the shifter
  // state that was just loaded or shifted.
  assign out_en_s = (phase_q == 2'd0);

  // Pixel-rate divider, shifter/flag loading, FLASH counter and parity next state.
  always_comb begin
    phase_d     = phase_q + 2'd1;
    shift_d     = shift_q;
    attr_d      = attr_q;
    area_d      = area_q;
    blank_d     = blank_q;
    pix_par_d   = pix_par_q;
    if (pix_ce_s) begin
      pix_par_d = ~pix_par_q;
      area_d    = screen_active;
      blank_d   = blank;
      if (load) begin
        shift_d = bitmap;
        attr_d  = attr;
      end else begin
        // Zero fill: once all eight bits are out the cell shows paper.
        shift_d = {shift_q[6:0], 1'b0};
      end
    end else begin
      pix_par_d = pix_par_q;
    end
    if (frame_start) begin
      flash_cnt_d = flash_cnt_q + 5'd1;
      frame_par_d = ~frame_par_q;
    end else begin
      flash_cnt_d = flash_cnt_q;
      frame_par_d = frame_par_q;
    end
  end

  // Standard colour resolve: FLASH swap, border/blank selection, level map.
  always_comb begin
    ink_s    = attr_q[2:0];
    paper_s  = attr_q[5:3];
    idx_s    = 3'b000;
    bright_s = 1'b0;
    if (attr_q[7] && flash_cnt_q[4]) begin
      ink_s   = attr_q[5:3];
      paper_s = attr_q[2:0];
    end else begin
      ink_s   = attr_q[2:0];
      paper_s = attr_q[5:3];
    end
    if (blank_q) begin
      idx_s    = 3'b000;
      bright_s = 1'b0;
    end else if (!area_q) begin
      idx_s    = border;
      bright_s = 1'b0;
    end else begin
      idx_s    = shift_q[7] ? ink_s : paper_s;
      bright_s = attr_q[6];
    end
    col_g_s = level3(idx_s[2], bright_s);
    col_r_s = level3(idx_s[1], bright_s);
    col_b_s = level2(idx_s[0], bright_s);
  end

`ifdef ULAPLUS_EN
  logic [7:0] pal_q [0:63];
  logic [5:0] pal_idx_s;
  logic [7:0] pal_ent_s;

  // Palette register file; written in any cycle, deliberately not reset.
  always_ff @(posedge clk28) begin
    if (pal_wr) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  // Palette index selection; FLASH swap and bright do not apply here.
  always_comb begin
    pal_idx_s = 6'd0;
    if (!area_q) begin
      pal_idx_s = {3'b001, border};
    end else if (shift_q[7]) begin
      pal_idx_s = {attr_q[7:6], 1'b0, attr_q[2:0]};
    end else begin
      pal_idx_s = {attr_q[7:6], 1'b1, attr_q[5:3]};
    end
  end

  // Read sees the pre-write contents when a write hits the same entry.
  assign pal_ent_s = pal_q[pal_idx_s];

  // Output next state: palette or standard colour, held between pixel updates.
  always_comb begin
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    strobe_d = strobe_q;
    if (out_en_s) begin
      strobe_d = pix_par_q ^ frame_par_q;
      if (ulaplus_mode) begin
        if (blank_q) begin
          r_d = 3'b000;
          g_d = 3'b000;
          b_d = 2'b00;
        end else begin
          g_d = pal_ent_s[7:5];
          r_d = pal_ent_s[4:2];
          b_d = pal_ent_s[1:0];
        end
      end else begin
        r_d = col_r_s;
        g_d = col_g_s;
        b_d = col_b_s;
      end
    end else begin
      strobe_d = strobe_q;
    end
  end
`else
  logic unused_pal_s;
  assign unused_pal_s = ^{pal_wr, pal_addr, pal_data, ulaplus_mode};

  // Output next state: standard colour, held between pixel updates.
  always_comb begin
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    strobe_d = strobe_q;
    if (out_en_s) begin
      r_d      = col_r_s;
      g_d      = col_g_s;
      b_d      = col_b_s;
      strobe_d = pix_par_q ^ frame_par_q;
    end else begin
      strobe_d = strobe_q;
    end
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk28) begin
    if (rst) begin
      phase_q     <= 2'd0;
      shift_q     <= 8'h00;
      attr_q      <= 8'h00;
      area_q      <= 1'b0;
      blank_q     <= 1'b1;
      flash_cnt_q <= 5'd0;
      pix_par_q   <= 1'b0;
      frame_par_q <= 1'b0;
      r_q         <= 3'b000;
      g_q         <= 3'b000;
      b_q         <= 2'b00;
      strobe_q    <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      attr_q      <= attr_d;
      area_q      <= area_d;
      blank_q     <= blank_d;
      flash_cnt_q <= flash_cnt_d;
      pix_par_q   <= pix_par_d;
      frame_par_q <= frame_par_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      strobe_q    <= strobe_d;
    end
  end

  assign r      = r_q;
  assign g      = g_q;
  assign b      = b_q;
  assign strobe = strobe_q;

endmodule

// File: tb/tb_video_pixel_serializer.sv
// Scoreboard bench for video_pixel_serializer. Stimulus pushes hand-computed
// expected pixels stamped with the output-update cycle; a monitor pops and
// compares them on the falling edge of that cycle.
module tb_video_pixel_serializer;

  logic       clk28 = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] bitmap = 8'h00;
  logic [7:0] attr = 8'h00;
  logic [2:0] border = 3'b000;
  logic       screen_active = 1'b0;
  logic       blank = 1'b0;
  logic       frame_start = 1'b0;
  logic       pal_wr = 1'b0;
  logic [5:0] pal_addr = 6'd0;
  logic [7:0] pal_data = 8'h00;
  logic       ulaplus_mode = 1'b0;
  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;
  logic       strobe;

  typedef struct {
    int         cyc;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       s;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   fs_cnt = 0;

  video_pixel_serializer dut (
    .clk28(clk28), .rst(rst), .load(load), .bitmap(bitmap), .attr(attr),
    .border(border), .screen_active(screen_active), .blank(blank),
    .frame_start(frame_start), .pal_wr(pal_wr), .pal_addr(pal_addr),
    .pal_data(pal_data), .ulaplus_mode(ulaplus_mode),
    .r(r), .g(g), .b(b), .strobe(strobe)
  );

  always #5 clk28 = ~clk28;

  // Edges since the last reset edge; phase of the DUT equals cyc % 4.
  always @(posedge clk28) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected strobe: pix_ce edges before edge k are 4,8,..; plus frame pulses.
  task automatic push_exp(input int k, input logic [2:0] er, input logic [2:0] eg,
                          input logic [1:0] eb);
    exp_t e;
    e.cyc = k;
    e.r   = er;
    e.g   = eg;
    e.b   = eb;
    e.s   = ((((k - 1) / 4) + fs_cnt) % 2) == 1;
    q.push_back(e);
  endtask

  task automatic wait_neg(input int c);
    @(negedge clk28);
    while (cyc != c) @(negedge clk28);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk28);
    rst = 1'b0;
    fs_cnt = 0;
  endtask

  task automatic pulse_fs(input int c);
    wait_neg(c);
    frame_start = 1'b1;
    @(negedge clk28);
    frame_start = 1'b0;
    fs_cnt = fs_cnt + 1;
  endtask

  // Monitor: compare the DUT output against the queued expectation for this cycle.
  always @(negedge clk28) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL missed_pixel cyc=%0d (now %0d) not compared", mon_e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        checks = checks + 1;
        if ({r, g, b, strobe} !== {mon_e.r, mon_e.g, mon_e.b, mon_e.s}) begin
          errors = errors + 1;
          $display("FAIL pixel cyc=%0d got r=%0d g=%0d b=%0d strobe=%0d expected r=%0d g=%0d b=%0d strobe=%0d",
                   cyc, r, g, b, strobe, mon_e.r, mon_e.g, mon_e.b, mon_e.s);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'hA5;

    // Reset: black, strobe 0 at the first output update.
    do_reset();
    push_exp(1, 3'd0, 3'd0, 2'd0);

    // Bitmap A5 with bright white ink on black paper, loaded at edge 4.
    wait_neg(3);
    load = 1'b1; bitmap = 8'hA5; attr = 8'h47; screen_active = 1'b1; blank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pat[7 - i]) push_exp(5 + 4 * i, 3'd7, 3'd7, 2'd3);
      else            push_exp(5 + 4 * i, 3'd0, 3'd0, 2'd0);
    end
    wait_neg(4);
    load = 1'b0;

    // Border area (red, never bright), then blanking.
    wait_neg(35);
    screen_active = 1'b0; border = 3'b010;
    push_exp(37, 3'd5, 3'd0, 2'd0);
    wait_neg(39);
    blank = 1'b1;
    push_exp(41, 3'd0, 3'd0, 2'd0);

    // FLASH: ink white / paper black, load held so every pixel is ink.
    wait_neg(43);
    blank = 1'b0; screen_active = 1'b1; load = 1'b1; bitmap = 8'hFF; attr = 8'h87;
    push_exp(45, 3'd5, 3'd5, 2'd2);
    push_exp(49, 3'd5, 3'd5, 2'd2);
    for (int j = 0; j < 16; j++) pulse_fs(50 + 3 * j);
    push_exp(101, 3'd0, 3'd0, 2'd0);
    push_exp(105, 3'd0, 3'd0, 2'd0);
    for (int j = 0; j < 16; j++) pulse_fs(106 + 3 * j);
    push_exp(157, 3'd5, 3'd5, 2'd2);
    push_exp(161, 3'd5, 3'd5, 2'd2);
    // One more frame: strobe phase inverts, FLASH still off.
    pulse_fs(162);
    push_exp(165, 3'd5, 3'd5, 2'd2);
    push_exp(169, 3'd5, 3'd5, 2'd2);
    wait_neg(170);
    load = 1'b0;

    // Reset mid-line: black until the next load.
    wait_neg(173);
    do_reset();
    push_exp(1, 3'd0, 3'd0, 2'd0);
    push_exp(5, 3'd0, 3'd0, 2'd0);

`ifdef ULAPLUS_EN
    wait_neg(5);
    pal_wr = 1'b1; pal_addr = 6'd1; pal_data = 8'hE3;
    wait_neg(6);
    pal_addr = 6'd8; pal_data = 8'h1C;
    wait_neg(7);
    pal_wr = 1'b0; ulaplus_mode = 1'b1; attr = 8'h01; bitmap = 8'h80; load = 1'b1;
    push_exp(9, 3'd0, 3'd7, 2'd3);
    push_exp(13, 3'd7, 3'd0, 2'd0);
    wait_neg(8);
    load = 1'b0;
    // Write to entry 8 on an output-update edge: old data first, new next.
    wait_neg(16);
    pal_wr = 1'b1; pal_addr = 6'd8; pal_data = 8'h02;
    push_exp(17, 3'd7, 3'd0, 2'd0);
    push_exp(21, 3'd0, 3'd0, 2'd2);
    wait_neg(17);
    pal_wr = 1'b0;
    wait_neg(22);
    ulaplus_mode = 1'b0;
`endif

    repeat (12) @(negedge clk28);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL unchecked_pixel cyc=%0d never compared", mon_e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
